mealy_1011_detector: RTL and testbench
======================================

# mealy_1011_detector

Serial Mealy-type sequence detector that flags every occurrence of the bit pattern 1011 (overlapping allowed) on a qualified serial input stream. It is the control layer over a bank of rising-edge D flip-flops that hold the FSM state, plus an optional detection counter. It sits between the serial input stage and the board-level indicators and counter readout.

## Interface
Parameters:
- CNT_W, 8, width of the detection counter (≥ 2).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- din  input  1  serial data bit.
- din_valid  input  1  qualifies din; the FSM advances only when this is 1.
- clear  input  1  synchronous clear of the FSM and counter.
- detect  output  1  Mealy output, combinational, valid in the same cycle as the qualifying bit.
- detect_q  output  1  detect registered, one cycle later.
- state_o  output  2  current FSM state encoding.
- det_count  output  CNT_W  saturating detection count (present only with the macro).
- overflow  output  1  sticky saturation flag (present only with the macro).

## Operation
- States (2-bit encoding): S0=00 (no prefix), S1=01 ("1"), S2=10 ("10"), S3=11 ("101").
- Transitions on a valid bit: S0: 1→S1, 0→S0 | S1: 1→S1, 0→S2 | S2: 1→S3, 0→S0 | S3: 1→S1 with detect, 0→S2.
- detect = din_valid & ~clear & (state==S3) & din. No other path asserts it.
- din_valid=0: state holds, detect=0, din ignored.
- clear=1: next state S0, detect forced 0, counter and overflow cleared next edge; clear overrides din_valid.
- Counter: +1 on each edge where detect=1; saturates at 2^CNT_W−1; the edge that would wrap sets overflow instead and leaves the count at max. overflow stays set until clear or reset.

## Timing
- reset asserted: immediately (no clock needed) state=S0, detect_q=0, det_count=0, overflow=0; detect=0 because state=S0. Hold values until the first rising edge after deassertion.
- Reset mid-sequence discards partial prefix; pattern must restart from scratch.
- detect: zero latency (combinational from din, din_valid, clear, state).
- detect_q, state_o, det_count: update on the rising edge that consumes the bit; latency 1 cycle.
- Back-to-back valid bits at full rate supported; no backpressure.
- Overlap: 1011011 yields two detections (bits 4 and 7).

## Configuration
- DETECT_COUNTER_EN defined: det_count and overflow ports and counter logic exist as described.
- Undefined: ports absent, no counter flip-flops; FSM, detect, detect_q unchanged.

## Structure
- Shared package: state encodings S0..S3, state width constant (2), pattern constant 4'b1011 for bench reference model.
- One sub-module: state_reg — CNT_W-independent 2-bit rising-edge register with asynchronous active-high reset to S0 and synchronous load; the FSM next-state logic and counter live in the top.

## Test plan
- Reset, then valid stream 1,0,1,1 → detect=1 only during the 4th bit; detect_q=1 the following cycle; det_count=1.
- Stream 1,0,1,1,0,1,1 continuous valid → detect on bits 4 and 7; det_count=2; final state S1.
- Stream 1,0,1 then din_valid=0 for 5 cycles with din toggling, then valid 1 → state stays S3 during gap; single detect on the final bit.
- clear=1 in the same cycle as the qualifying final 1 of 1011 → detect=0, next state S0, det_count=0.
- CNT_W=2, feed 4 overlapped matches → det_count stops at 3, overflow=1 after the 4th; stays 1 until clear.
- Assert reset asynchronously between edges after 1,0,1 → state_o=00, det_count=0, overflow=0 immediately; following 1 gives no detect.

Source files
------------

// File: rtl/mealy_1011_detector_pkg.sv
// Shared definitions for the 1011 Mealy sequence detector: state encodings,
// widths, the reference pattern and the transition/match helpers.
package mealy_1011_detector_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned PAT_W   = 4;

    // Pattern being detected, kept here so reference models share one copy.
    localparam logic [PAT_W-1:0] PATTERN = 4'b1011;

    // Each state names the longest prefix of PATTERN seen so far.
    typedef enum logic [STATE_W-1:0] {
        S0 = 2'b00,  // no prefix
        S1 = 2'b01,  // "1"
        S2 = 2'b10,  // "10"
        S3 = 2'b11   // "101"
    } state_t;

    // Next state after consuming one qualified bit (overlap-preserving).
    function automatic state_t next_state(input state_t cur, input logic bit_in);
        state_t nxt;
        nxt = S0;
        unique case (cur)
            S0: nxt = bit_in ? S1 : S0;
            S1: nxt = bit_in ? S1 : S2;
            S2: nxt = bit_in ? S3 : S0;
            S3: nxt = bit_in ? S1 : S2;
        endcase
        return nxt;
    endfunction

    // A full match completes when "101" is followed by a 1.
    function automatic logic is_match(input state_t cur, input logic bit_in);
        return (cur == S3) && bit_in;
    endfunction

endpackage : mealy_1011_detector_pkg

// File: rtl/mealy_1011_detector_state_reg.sv
// 2-bit FSM state register: asynchronous active-high reset to S0,
// synchronous load of the next state when load is high.
module mealy_1011_detector_state_reg
    import mealy_1011_detector_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   load,
    input  state_t d,
    output state_t q
);

    // Hold the current state unless a new one is loaded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= S0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule : mealy_1011_detector_state_reg

// File: rtl/mealy_1011_detector.sv
// Serial Mealy detector for the pattern 1011 with overlap.
// detect is combinational in the cycle of the completing bit; detect_q is its
// registered copy. Optional saturating detection counter with sticky overflow
// is built when the macro DETECT_COUNTER_EN is defined.
module mealy_1011_detector
    import mealy_1011_detector_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               din,
    input  logic               din_valid,
    input  logic               clear,
    output logic               detect,
    output logic               detect_q,
    output logic [STATE_W-1:0] state_o
`ifdef DETECT_COUNTER_EN
    ,
    output logic [CNT_W-1:0]   det_count,
    output logic               overflow
`endif
);

    state_t state;
    state_t state_nxt;
    logic   state_load;

    // Next-state and Mealy output; clear takes priority over a valid bit.
    always_comb begin
        state_nxt  = state;
        state_load = 1'b0;
        detect     = 1'b0;
        if (clear) begin
            state_nxt  = S0;
            state_load = 1'b1;
        end else if (din_valid) begin
            state_nxt  = next_state(state, din);
            state_load = 1'b1;
            detect     = is_match(state, din);
        end
    end

    mealy_1011_detector_state_reg u_state_reg (
        .clk   (clk),
        .reset (reset),
        .load  (state_load),
        .d     (state_nxt),
        .q     (state)
    );

    assign state_o = state;

    // One-cycle delayed copy of detect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            detect_q <= 1'b0;
        end else begin
            detect_q <= detect;
        end
    end

`ifdef DETECT_COUNTER_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Saturating detection count; the would-be wrapping edge sets overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            det_count <= '0;
            overflow  <= 1'b0;
        end else if (clear) begin
            det_count <= '0;
            overflow  <= 1'b0;
        end else if (detect) begin
            if (det_count == CNT_MAX) begin
                overflow <= 1'b1;
            end else begin
                det_count <= det_count + CNT_W'(1);
            end
        end
    end
`else
    // CNT_W only sizes the counter; without it the parameter has no role.
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W > 1);
`endif

endmodule : mealy_1011_detector

// File: tb/tb_mealy_1011_detector.sv
// Directed self-checking bench for mealy_1011_detector.
// Counter checks are compiled in only when DETECT_COUNTER_EN is defined.
module tb_mealy_1011_detector;

    localparam int unsigned CNT_W = 2;

    logic             clk;
    logic             reset;
    logic             din;
    logic             din_valid;
    logic             clear;
    logic             detect;
    logic             detect_q;
    logic [1:0]       state_o;
`ifdef DETECT_COUNTER_EN
    logic [CNT_W-1:0] det_count;
    logic             overflow;
`endif

    int passed = 0;
    int total  = 0;

    mealy_1011_detector #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .clear     (clear),
        .detect    (detect),
        .detect_q  (detect_q),
        .state_o   (state_o)
`ifdef DETECT_COUNTER_EN
        ,
        .det_count (det_count),
        .overflow  (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs mid-cycle and let combinational detect settle.
    task automatic set_in(input logic d, input logic v, input logic c);
        din       = d;
        din_valid = v;
        clear     = c;
        #1;
    endtask

    // Advance one rising edge and sample just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        set_in(1'b0, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        din = 1'b0; din_valid = 1'b0; clear = 1'b0;
        #3;
        total++; if (state_o !== 2'b00) $display("FAIL reset_state got %b expected 00", state_o); else passed++;
        total++; if (detect_q !== 1'b0) $display("FAIL reset_detect_q got %b expected 0", detect_q); else passed++;
        total++; if (detect !== 1'b0) $display("FAIL reset_detect got %b expected 0", detect); else passed++;
`ifdef DETECT_COUNTER_EN
        total++; if (det_count !== '0) $display("FAIL reset_count got %0d expected 0", det_count); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b expected 0", overflow); else passed++;
`endif
        tick();
        reset = 1'b0;
        tick();
        total++; if (state_o !== 2'b00) $display("FAIL post_reset_state got %b expected 00", state_o); else passed++;
    endtask

    task automatic test_basic();
        logic [3:0] seq  = 4'b1011;
        logic [3:0] expd = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            set_in(seq[3-i], 1'b1, 1'b0);
            total++; if (detect !== expd[3-i]) $display("FAIL basic_detect bit %0d got %b expected %b", i+1, detect, expd[3-i]); else passed++;
            tick();
        end
        total++; if (detect_q !== 1'b1) $display("FAIL basic_detect_q got %b expected 1", detect_q); else passed++;
        total++; if (state_o !== 2'b01) $display("FAIL basic_state got %b expected 01", state_o); else passed++;
`ifdef DETECT_COUNTER_EN
        total++; if (det_count !== CNT_W'(1)) $display("FAIL basic_count got %0d expected 1", det_count); else passed++;
`endif
        set_in(1'b0, 1'b0, 1'b0);
        tick();
        total++; if (detect_q !== 1'b0) $display("FAIL basic_detect_q_drop got %b expected 0", detect_q); else passed++;
    endtask

    task automatic test_overlap();
        logic [6:0] seq  = 7'b1011011;
        logic [6:0] expd = 7'b0001001;
        do_clear();
        for (int i = 0; i < 7; i++) begin
            set_in(seq[6-i], 1'b1, 1'b0);
            total++; if (detect !== expd[6-i]) $display("FAIL overlap_detect bit %0d got %b expected %b", i+1, detect, expd[6-i]); else passed++;
            tick();
        end
        set_in(1'b0, 1'b0, 1'b0);
        total++; if (state_o !== 2'b01) $display("FAIL overlap_state got %b expected 01", state_o); else passed++;
`ifdef DETECT_COUNTER_EN
        total++; if (det_count !== CNT_W'(2)) $display("FAIL overlap_count got %0d expected 2", det_count); else passed++;
`endif
    endtask

    task automatic test_valid_gap();
        logic [2:0] seq = 3'b101;
        do_clear();
        for (int i = 0; i < 3; i++) begin
            set_in(seq[2-i], 1'b1, 1'b0);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            set_in(i[0] ? 1'b0 : 1'b1, 1'b0, 1'b0);
            total++; if (detect !== 1'b0) $display("FAIL gap_detect cycle %0d got %b expected 0", i, detect); else passed++;
            tick();
            total++; if (state_o !== 2'b11) $display("FAIL gap_state cycle %0d got %b expected 11", i, state_o); else passed++;
        end
        set_in(1'b1, 1'b1, 1'b0);
        total++; if (detect !== 1'b1) $display("FAIL gap_final_detect got %b expected 1", detect); else passed++;
        tick();
        set_in(1'b0, 1'b0, 1'b0);
`ifdef DETECT_COUNTER_EN
        total++; if (det_count !== CNT_W'(1)) $display("FAIL gap_count got %0d expected 1", det_count); else passed++;
`endif
    endtask

    task automatic test_clear_override();
        logic [2:0] seq = 3'b101;
        do_clear();
        for (int i = 0; i < 3; i++) begin
            set_in(seq[2-i], 1'b1, 1'b0);
            tick();
        end
        set_in(1'b1, 1'b1, 1'b1);
        total++; if (detect !== 1'b0) $display("FAIL clear_detect got %b expected 0", detect); else passed++;
        tick();
        set_in(1'b0, 1'b0, 1'b0);
        total++; if (state_o !== 2'b00) $display("FAIL clear_state got %b expected 00", state_o); else passed++;
        total++; if (detect_q !== 1'b0) $display("FAIL clear_detect_q got %b expected 0", detect_q); else passed++;
`ifdef DETECT_COUNTER_EN
        total++; if (det_count !== '0) $display("FAIL clear_count got %0d expected 0", det_count); else passed++;
`endif
    endtask

`ifdef DETECT_COUNTER_EN
    task automatic test_saturate();
        logic [12:0] seq  = 13'b1011011011011;
        logic [12:0] expd = 13'b0001001001001;
        do_clear();
        for (int i = 0; i < 13; i++) begin
            set_in(seq[12-i], 1'b1, 1'b0);
            total++; if (detect !== expd[12-i]) $display("FAIL sat_detect bit %0d got %b expected %b", i+1, detect, expd[12-i]); else passed++;
            tick();
            if (i == 9) begin
                total++; if (det_count !== CNT_W'(3)) $display("FAIL sat_count_third got %0d expected 3", det_count); else passed++;
                total++; if (overflow !== 1'b0) $display("FAIL sat_ovf_third got %b expected 0", overflow); else passed++;
            end
        end
        set_in(1'b0, 1'b0, 1'b0);
        total++; if (det_count !== CNT_W'(3)) $display("FAIL sat_count_max got %0d expected 3", det_count); else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL sat_ovf_set got %b expected 1", overflow); else passed++;
        for (int i = 0; i < 3; i++) tick();
        total++; if (overflow !== 1'b1) $display("FAIL sat_ovf_sticky got %b expected 1", overflow); else passed++;
        do_clear();
        total++; if (overflow !== 1'b0) $display("FAIL sat_ovf_cleared got %b expected 0", overflow); else passed++;
        total++; if (det_count !== '0) $display("FAIL sat_count_cleared got %0d expected 0", det_count); else passed++;
    endtask
`endif

    task automatic test_async_reset();
        logic [5:0] seq = 6'b101101;
        do_clear();
        for (int i = 0; i < 6; i++) begin
            set_in(seq[5-i], 1'b1, 1'b0);
            tick();
        end
        set_in(1'b0, 1'b0, 1'b0);
        total++; if (state_o !== 2'b11) $display("FAIL areset_pre_state got %b expected 11", state_o); else passed++;
        #2;
        reset = 1'b1;
        #1;
        total++; if (state_o !== 2'b00) $display("FAIL areset_state got %b expected 00", state_o); else passed++;
        total++; if (detect_q !== 1'b0) $display("FAIL areset_detect_q got %b expected 0", detect_q); else passed++;
`ifdef DETECT_COUNTER_EN
        total++; if (det_count !== '0) $display("FAIL areset_count got %0d expected 0", det_count); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL areset_overflow got %b expected 0", overflow); else passed++;
`endif
        reset = 1'b0;
        tick();
        set_in(1'b1, 1'b1, 1'b0);
        total++; if (detect !== 1'b0) $display("FAIL areset_no_detect got %b expected 0", detect); else passed++;
        tick();
        set_in(1'b0, 1'b0, 1'b0);
        total++; if (state_o !== 2'b01) $display("FAIL areset_restart_state got %b expected 01", state_o); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overlap();
        test_valid_gap();
        test_clear_override();
`ifdef DETECT_COUNTER_EN
        test_saturate();
`endif
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_mealy_1011_detector
